// File: rtl/sdram_wbaxi.sv
// sdram_wbaxi: pipelined Wishbone slave bridged to single-beat AXI4 transfers toward an SDRAM controller
module sdram_wbaxi #(
  parameter int C_AXI_ID_WIDTH = 1,
  parameter int C_AXI_DATA_WIDTH = 128,
  parameter int C_AXI_ADDR_WIDTH = 28,
  parameter int DW = 32,
  parameter int LGFIFO = 5,
  localparam int AW = C_AXI_ADDR_WIDTH - $clog2(DW / 8),
  localparam int NLANE = C_AXI_DATA_WIDTH / DW
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_calib_done,
  input  logic i_wb_cyc,
  input  logic i_wb_stb,
  input  logic i_wb_we,
  input  logic [AW-1:0] i_wb_addr,
  input  logic [DW-1:0] i_wb_data,
  input  logic [DW/8-1:0] i_wb_sel,
  output logic o_wb_stall,
  output logic o_wb_ack,
  output logic o_wb_err,
  output logic [DW-1:0] o_wb_data,
  output logic [C_AXI_ID_WIDTH-1:0] o_axi_awid,
  output logic [C_AXI_ADDR_WIDTH-1:0] o_axi_awaddr,
  output logic [7:0] o_axi_awlen,
  output logic [2:0] o_axi_awsize,
  output logic [1:0] o_axi_awburst,
  output logic o_axi_awvalid,
  input  logic i_axi_awready,
  output logic [C_AXI_DATA_WIDTH-1:0] o_axi_wdata,
  output logic [C_AXI_DATA_WIDTH/8-1:0] o_axi_wstrb,
  output logic o_axi_wlast,
  output logic o_axi_wvalid,
  input  logic i_axi_wready,
  input  logic [C_AXI_ID_WIDTH-1:0] i_axi_bid,
  input  logic [1:0] i_axi_bresp,
  input  logic i_axi_bvalid,
  output logic o_axi_bready,
  output logic [C_AXI_ID_WIDTH-1:0] o_axi_arid,
  output logic [C_AXI_ADDR_WIDTH-1:0] o_axi_araddr,
  output logic [7:0] o_axi_arlen,
  output logic [2:0] o_axi_arsize,
  output logic [1:0] o_axi_arburst,
  output logic o_axi_arvalid,
  input  logic i_axi_arready,
  input  logic [C_AXI_ID_WIDTH-1:0] i_axi_rid,
  input  logic [C_AXI_DATA_WIDTH-1:0] i_axi_rdata,
  input  logic [1:0] i_axi_rresp,
  input  logic i_axi_rlast,
  input  logic i_axi_rvalid,
  output logic o_axi_rready
);
  localparam int WBLSB = $clog2(DW / 8);
  localparam int AXLSB = $clog2(C_AXI_DATA_WIDTH / 8);
  localparam int LW = NLANE > 1 ? $clog2(NLANE) : 1;
  localparam int SW = C_AXI_DATA_WIDTH / 8;
  localparam int DEPTH = 1 << LGFIFO;
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
  state_t state_q, state_d;
  logic [LGFIFO:0] count_q, count_d;
  logic [LGFIFO-1:0] wr_q, wr_d, rd_q, rd_d;
  logic dir_q, dir_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic ack_q, ack_d, err_q, err_d;
  logic [C_AXI_ADDR_WIDTH-1:0] addr_q, addr_d, byte_addr;
  logic [C_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [LW-1:0] lane_mem [DEPTH];
  logic [LW-1:0] lane, rd_lane;
  logic acc, rsp, rsp_err, live, unused_ok;
  assign lane = NLANE > 1 ? i_wb_addr[LW-1:0] : '0;
  assign rd_lane = lane_mem[rd_q];
  assign byte_addr = {i_wb_addr, {WBLSB{1'b0}}};
  assign o_wb_stall = !i_calib_done || count_q[LGFIFO] || (awvalid_q && !i_axi_awready) ||
                      (wvalid_q && !i_axi_wready) || (arvalid_q && !i_axi_arready) ||
                      (count_q != '0 && i_wb_we != dir_q) || state_q == DRAIN;
  assign acc = i_wb_cyc && i_wb_stb && !o_wb_stall;
  assign rsp = count_q != '0 && (dir_q ? i_axi_bvalid : i_axi_rvalid);
  assign rsp_err = dir_q ? i_axi_bresp[1] : i_axi_rresp[1];
  assign live = state_q != DRAIN && i_wb_cyc;
  always_comb begin
    count_d = count_q + (LGFIFO + 1)'(acc) - (LGFIFO + 1)'(rsp);
    wr_d = wr_q + LGFIFO'(acc && !i_wb_we);
    rd_d = rd_q + LGFIFO'(rsp && !dir_q);
    dir_d = acc ? i_wb_we : dir_q;
    addr_d = acc ? (byte_addr >> AXLSB) << AXLSB : addr_q;
    awvalid_d = acc ? i_wb_we : awvalid_q && !i_axi_awready;
    wvalid_d = acc ? i_wb_we : wvalid_q && !i_axi_wready;
    arvalid_d = acc ? !i_wb_we : arvalid_q && !i_axi_arready;
    wdata_d = acc && i_wb_we ? {NLANE{i_wb_data}} : wdata_q;
    wstrb_d = acc && i_wb_we ? SW'(i_wb_sel) << (lane * (DW / 8)) : wstrb_q;
    rdata_d = rsp && !dir_q ? DW'(i_axi_rdata >> (rd_lane * DW)) : rdata_q;
    ack_d = rsp && !rsp_err && live;
    err_d = rsp && rsp_err && live;
    state_d = count_d == '0 ? IDLE :
              (state_q == DRAIN || (rsp && rsp_err) || !i_wb_cyc) ? DRAIN : BUSY;
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      dir_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q <= 1'b0;
      arvalid_q <= 1'b0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      dir_q <= dir_d;
      awvalid_q <= awvalid_d;
      wvalid_q <= wvalid_d;
      arvalid_q <= arvalid_d;
      ack_q <= ack_d;
      err_q <= err_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
    end
  always_ff @(posedge i_clk)
    if (acc && !i_wb_we) lane_mem[wr_q] <= lane;
  assign o_wb_ack = ack_q && i_wb_cyc;
  assign o_wb_err = err_q && i_wb_cyc;
  assign o_wb_data = rdata_q;
  assign o_axi_awid = '0;
  assign o_axi_awaddr = addr_q;
  assign o_axi_awlen = 8'd0;
  assign o_axi_awsize = 3'(AXLSB);
  assign o_axi_awburst = 2'b01;
  assign o_axi_awvalid = awvalid_q;
  assign o_axi_wdata = wdata_q;
  assign o_axi_wstrb = wstrb_q;
  assign o_axi_wlast = 1'b1;
  assign o_axi_wvalid = wvalid_q;
  assign o_axi_bready = 1'b1;
  assign o_axi_arid = '0;
  assign o_axi_araddr = addr_q;
  assign o_axi_arlen = 8'd0;
  assign o_axi_arsize = 3'(AXLSB);
  assign o_axi_arburst = 2'b01;
  assign o_axi_arvalid = arvalid_q;
  assign o_axi_rready = 1'b1;
  assign unused_ok = ^{i_axi_bid, i_axi_rid, i_axi_rlast, i_axi_bresp[0], i_axi_rresp[0]};
endmodule

// File: tb/tb_sdram_wbaxi.sv
// tb_sdram_wbaxi: directed and randomized checks of sdram_wbaxi against a queue-based reference model
module tb_sdram_wbaxi;
  logic clk = 0, rst_n = 0, calib = 1;
  logic cyc = 0, stb = 0, we = 0;
  logic [25:0] addr = 0;
  logic [31:0] wdat = 0;
  logic [3:0] sel = 0;
  logic stall, ack, err;
  logic [31:0] rdat;
  logic [0:0] awid, arid;
  logic [27:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst;
  logic awvalid, arvalid, wvalid, wlast, bready, rready;
  logic awready = 1, wready = 1, arready = 1;
  logic [127:0] wdata;
  logic [15:0] wstrb;
  logic bvalid = 0, rvalid = 0;
  logic [1:0] bresp = 0, rresp = 0;
  logic [127:0] rdata = 0;
  int n_chk = 0, n_fail = 0;
  typedef struct packed {logic we; logic [1:0] lane;} rsp_t;
  rsp_t rq[$];
  rsp_t r;
  logic [27:0] aw_q[$], ar_q[$];
  logic [127:0] wd_q[$];
  logic [15:0] ws_q[$];
  int aw_tot, w_tot, ar_tot, b_tot, r_tot, st;
  logic drain, exp_ack, exp_err, exp_rd, req, m_we, wind, rsp, e, stall_exp;
  logic [25:0] m_addr;
  logic [31:0] m_data, exp_data;
  logic [3:0] m_sel;
  logic [127:0] rd_save;

  sdram_wbaxi dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_calib_done(calib),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr), .i_wb_data(wdat), .i_wb_sel(sel),
    .o_wb_stall(stall), .o_wb_ack(ack), .o_wb_err(err), .o_wb_data(rdat),
    .o_axi_awid(awid), .o_axi_awaddr(awaddr), .o_axi_awlen(awlen), .o_axi_awsize(awsize),
    .o_axi_awburst(awburst), .o_axi_awvalid(awvalid), .i_axi_awready(awready),
    .o_axi_wdata(wdata), .o_axi_wstrb(wstrb), .o_axi_wlast(wlast), .o_axi_wvalid(wvalid), .i_axi_wready(wready),
    .i_axi_bid(1'b0), .i_axi_bresp(bresp), .i_axi_bvalid(bvalid), .o_axi_bready(bready),
    .o_axi_arid(arid), .o_axi_araddr(araddr), .o_axi_arlen(arlen), .o_axi_arsize(arsize),
    .o_axi_arburst(arburst), .o_axi_arvalid(arvalid), .i_axi_arready(arready),
    .i_axi_rid(1'b0), .i_axi_rdata(rdata), .i_axi_rresp(rresp), .i_axi_rlast(1'b1),
    .i_axi_rvalid(rvalid), .o_axi_rready(rready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_data", rdat, 0);
    check("rst_ready", {bready, rready}, 2'b11);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; addr = 26'h5; wdat = 32'hDEADBEEF; sel = 4'hF;
    awready = 0; wready = 0;
    #1 check("w_stall", stall, 0);
    @(negedge clk);
    stb = 0;
    #1;
    check("w_awvalid", awvalid, 1);
    check("w_wvalid", wvalid, 1);
    check("w_awaddr", awaddr, 28'h10);
    check("w_wstrb", wstrb, 16'h00F0);
    check("w_wdata_lane1", wdata[63:32], 32'hDEADBEEF);
    check("w_wdata_rep", wdata, {4{32'hDEADBEEF}});
    check("w_burst", {awlen, awsize, awburst, wlast}, {8'd0, 3'd4, 2'b01, 1'b1});
    awready = 1;
    @(negedge clk);
    check("w_aw_drop", awvalid, 0);
    check("w_w_hold", wvalid, 1);
    check("w_wstrb_hold", wstrb, 16'h00F0);
    wready = 1;
    @(negedge clk);
    check("w_w_drop", wvalid, 0);
    bvalid = 1; bresp = 2'b00;
    @(negedge clk);
    bvalid = 0;
    check("w_ack", ack, 1);
    check("w_err", err, 0);
    @(negedge clk);
    check("w_ack_once", ack, 0);

    we = 0; stb = 1; st = 0;
    for (int i = 0; i < 32; i++) begin
      addr = 26'(i);
      #1 if (stall) st++;
      @(negedge clk);
    end
    check("rd32_no_stall", st, 0);
    check("rd32_arsize", {arlen, arsize, arburst}, {8'd0, 3'd4, 2'b01});
    addr = 26'd32;
    #1 check("rd33_stall", stall, 1);
    rvalid = 1; rresp = 0; rdata = {$urandom, $urandom, $urandom, $urandom};
    rd_save = rdata;
    #1 check("rd33_stall_hold", stall, 1);
    @(negedge clk);
    rvalid = 0;
    check("rd_first_ack", ack, 1);
    check("rd_first_data", rdat, rd_save[31:0]);
    #1 check("rd33_release", stall, 0);
    @(negedge clk);
    stb = 0;
    for (int i = 1; i <= 32; i++) begin
      rdata = {$urandom, $urandom, $urandom, $urandom};
      rvalid = 1;
      exp_data = rdata[(i % 4) * 32 +: 32];
      @(negedge clk);
      check("rd_burst_ack", ack, 1);
      check("rd_burst_data", rdat, exp_data);
    end
    rvalid = 0;
    @(negedge clk);
    check("rd_done_ack", ack, 0);

    stb = 1; we = 0; addr = 26'd2;
    @(negedge clk);
    we = 1; addr = 26'd7; wdat = 32'h12345678; sel = 4'h3;
    #1 check("dir_stall0", stall, 1);
    @(negedge clk);
    #1 check("dir_stall1", stall, 1);
    rvalid = 1; rdata = {$urandom, $urandom, $urandom, $urandom}; rd_save = rdata;
    @(negedge clk);
    rvalid = 0;
    check("dir_rd_ack", ack, 1);
    check("dir_rd_data", rdat, rd_save[95:64]);
    #1 check("dir_release", stall, 0);
    @(negedge clk);
    stb = 0;
    #1;
    check("dir_awvalid", awvalid, 1);
    check("dir_awaddr", awaddr, 28'h10);
    check("dir_wstrb", wstrb, 16'h3000);
    @(negedge clk);
    bvalid = 1;
    @(negedge clk);
    bvalid = 0;
    check("dir_wr_ack", ack, 1);

    we = 0; stb = 1;
    for (int i = 0; i < 3; i++) begin
      addr = 26'(i);
      @(negedge clk);
    end
    stb = 0;
    rvalid = 1; rresp = 2'b10;
    @(negedge clk);
    rresp = 2'b00;
    check("err_err", err, 1);
    check("err_noack", ack, 0);
    #1 check("err_drain_stall", stall, 1);
    @(negedge clk);
    check("drain_ack0", ack, 0);
    check("drain_err0", err, 0);
    #1 check("drain_stall", stall, 1);
    @(negedge clk);
    rvalid = 0;
    check("drain_ack1", ack, 0);
    #1 check("drain_clear", stall, 0);

    stb = 1; we = 0; addr = 26'd4;
    @(negedge clk);
    addr = 26'd5;
    @(negedge clk);
    stb = 0; cyc = 0;
    @(negedge clk);
    cyc = 1;
    #1 check("cyc_drain_stall", stall, 1);
    rvalid = 1;
    @(negedge clk);
    check("cyc_drain_ack0", ack, 0);
    @(negedge clk);
    rvalid = 0;
    check("cyc_drain_ack1", ack, 0);
    #1 check("cyc_drain_clear", stall, 0);

    rvalid = 1;
    @(negedge clk);
    rvalid = 0;
    check("idle_rsp_noack", ack, 0);
    #1 check("idle_rsp_nostall", stall, 0);

    we = 1; stb = 1; addr = 26'd9; awready = 0; wready = 0;
    @(negedge clk);
    stb = 0;
    check("rst_mid_awvalid", awvalid, 1);
    #2 rst_n = 0;
    #1;
    check("rst_mid_aw_drop", awvalid, 0);
    check("rst_mid_w_drop", wvalid, 0);
    check("rst_mid_count", dut.count_q, 0);
    calib = 0;
    #1 check("nocalib_stall", stall, 1);
    @(negedge clk);
    rst_n = 1; calib = 1; awready = 1; wready = 1; we = 0;
    @(negedge clk);
    #1;
    check("post_rst_stall", stall, 0);
    check("post_rst_awvalid", awvalid, 0);

    drain = 0; exp_ack = 0; exp_err = 0; exp_rd = 0; req = 0;
    aw_tot = 0; w_tot = 0; ar_tot = 0; b_tot = 0; r_tot = 0;
    m_we = 0; m_addr = 0; m_data = 0; m_sel = 0; exp_data = 0;
    for (int t = 0; t < 3400; t++) begin
      wind = t >= 3000;
      @(negedge clk);
      check("r_ack", ack, 1'(exp_ack && cyc));
      check("r_err", err, 1'(exp_err && cyc));
      if (exp_ack && exp_rd && cyc) check("r_data", rdat, exp_data);
      check("r_awvalid", awvalid, 1'(aw_q.size() != 0));
      check("r_wvalid", wvalid, 1'(wd_q.size() != 0));
      check("r_arvalid", arvalid, 1'(ar_q.size() != 0));
      if (wind && rq.size() == 0) break;
      cyc = wind || $urandom_range(0, 39) != 0;
      calib = wind || $urandom_range(0, 15) != 0;
      if (!cyc) req = 0;
      else if (!req && !wind && $urandom_range(0, 2) != 0) begin
        req = 1;
        m_we = (rq.size() != 0 && $urandom_range(0, 3) != 0) ? rq[0].we : 1'($urandom);
        m_addr = 26'($urandom);
        m_data = $urandom;
        m_sel = 4'($urandom);
      end
      stb = req;
      we = req ? m_we : 1'($urandom);
      addr = m_addr; wdat = m_data; sel = m_sel;
      awready = wind || $urandom_range(0, 2) != 0;
      wready = wind || $urandom_range(0, 2) != 0;
      arready = wind || $urandom_range(0, 2) != 0;
      bvalid = 0; rvalid = 0; e = 0;
      if (rq.size() != 0 && $urandom_range(0, 1) != 0) begin
        e = $urandom_range(0, 19) == 0;
        if (rq[0].we && aw_tot > b_tot && w_tot > b_tot) begin
          bvalid = 1; bresp = {e, 1'($urandom)};
        end else if (!rq[0].we && ar_tot > r_tot) begin
          rvalid = 1; rresp = {e, 1'($urandom)};
          rdata = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      #1;
      stall_exp = !calib || rq.size() == 32 || (aw_q.size() != 0 && !awready) ||
                  (wd_q.size() != 0 && !wready) || (ar_q.size() != 0 && !arready) ||
                  (rq.size() != 0 && we != rq[0].we) || drain;
      check("r_stall", stall, stall_exp);
      if (aw_q.size() != 0 && awready) begin
        check("r_awaddr", awaddr, aw_q.pop_front());
        aw_tot++;
      end
      if (wd_q.size() != 0 && wready) begin
        check("r_wdata", wdata, wd_q.pop_front());
        check("r_wstrb", wstrb, ws_q.pop_front());
        w_tot++;
      end
      if (ar_q.size() != 0 && arready) begin
        check("r_araddr", araddr, ar_q.pop_front());
        ar_tot++;
      end
      rsp = bvalid || rvalid;
      exp_ack = rsp && !e && cyc && !drain;
      exp_err = rsp && e && cyc && !drain;
      exp_rd = rvalid;
      if (rsp) begin
        r = rq.pop_front();
        exp_data = rdata[r.lane * 32 +: 32];
        if (bvalid) b_tot++;
        else r_tot++;
      end
      if (cyc && stb && !stall_exp) begin
        r.we = we; r.lane = addr[1:0];
        rq.push_back(r);
        if (we) begin
          aw_q.push_back({addr, 2'b00} & 28'hFFFFFF0);
          wd_q.push_back({4{wdat}});
          ws_q.push_back(16'(sel) << (4 * addr[1:0]));
        end else ar_q.push_back({addr, 2'b00} & 28'hFFFFFF0);
        req = 0;
      end
      drain = rq.size() != 0 && (drain || (rsp && e) || !cyc);
    end
    check("r_drain_timeout", rq.size(), 0);
    cyc = 1; stb = 0; calib = 1; bvalid = 0; rvalid = 0;
    #1 check("r_end_stall", stall, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
